// File: rtl/mem_stage_controller.sv
// mem_stage_controller: MEM-stage data-cache miss controller.
// Write-back, allocate-on-miss; holds the pipeline with lock while a miss is serviced.
module mem_stage_controller #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic        is_nop_mem,
  input  logic [31:0] ALU_result_mem,
  input  logic [31:0] victim_addr,
  input  logic        cache_hit,
  input  logic        cache_dirty,
  output logic        lock,
  output logic        we_cache,
  output logic        cache_input_type,
  output logic        set_dirty,
  output logic        set_valid,
  output logic        we_memory,
  output logic        memory_address_type,
  output logic [31:0] mem_block_addr,
  output logic [31:0] miss_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_REFILL
  } state_e;

  localparam logic [CNT_W-1:0] CntLast =
    CNT_W'(MEM_LATENCY - 1);
  localparam logic [31:0] BlkMask = ~32'h3;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        access;
  logic        last;

  assign access = (mem_read_mem | mem_write_mem) & ~is_nop_mem;
  assign last   = (cnt_q == CntLast);
  assign miss_count = miss_count_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      miss_addr_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_addr_q  <= miss_addr_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    miss_addr_d         = miss_addr_q;
    miss_count_d        = miss_count_q;
    lock                = 1'b0;
    we_cache            = 1'b0;
    cache_input_type    = 1'b0;
    set_dirty           = 1'b0;
    set_valid           = 1'b0;
    we_memory           = 1'b0;
    memory_address_type = 1'b0;
    mem_block_addr      = '0;
    case (state_q)
      S_IDLE: begin
        if (access && cache_hit) begin
          if (mem_write_mem) begin
            we_cache  = 1'b1;
            set_dirty = 1'b1;
            set_valid = 1'b1;
          end
        end else if (access) begin
          lock        = 1'b1;
          miss_addr_d = ALU_result_mem;
          cnt_d       = '0;
          state_d     = cache_dirty ? S_WB : S_REFILL;
          if (miss_count_q != '1)
            miss_count_d = miss_count_q + 32'd1;
        end
      end
      S_WB: begin
        lock                = 1'b1;
        we_memory           = 1'b1;
        memory_address_type = 1'b1;
        mem_block_addr      = victim_addr & BlkMask;
        if (last) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REFILL: begin
        lock           = 1'b1;
        mem_block_addr = miss_addr_q & BlkMask;
        if (last) begin
          we_cache         = 1'b1;
          cache_input_type = 1'b1;
          set_valid        = 1'b1;
          cnt_d            = '0;
          state_d          = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs must read 0 for the whole time reset is held.
    if (!rst_b) begin
      lock                = 1'b0;
      we_cache            = 1'b0;
      cache_input_type    = 1'b0;
      set_dirty           = 1'b0;
      set_valid           = 1'b0;
      we_memory           = 1'b0;
      memory_address_type = 1'b0;
      mem_block_addr      = '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_controller.sv
// tb_mem_stage_controller: directed plus random accesses
// against a per-transaction stall-schedule model.
module tb_mem_stage_controller;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        rd, wr, nop;
  logic [31:0] addr, victim;
  logic        hit, dirty;
  logic        lock, we_cache, cit, set_dirty, set_valid;
  logic        we_memory, mat;
  logic [31:0] blk, mcount;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_count = 0;

  mem_stage_controller #(.MEM_LATENCY(L), .CNT_W(8)) dut (
    .clk                (clk),
    .rst_b              (rst_b),
    .mem_read_mem       (rd),
    .mem_write_mem      (wr),
    .is_nop_mem         (nop),
    .ALU_result_mem     (addr),
    .victim_addr        (victim),
    .cache_hit          (hit),
    .cache_dirty        (dirty),
    .lock               (lock),
    .we_cache           (we_cache),
    .cache_input_type   (cit),
    .set_dirty          (set_dirty),
    .set_valid          (set_valid),
    .we_memory          (we_memory),
    .memory_address_type(mat),
    .mem_block_addr     (blk),
    .miss_count         (mcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ctrl = {lock,we_cache,cit,set_dirty,set_valid,we_memory,mat}
  function automatic logic [31:0] ctrl();
    return {25'd0, lock, we_cache, cit, set_dirty,
            set_valid, we_memory, mat};
  endfunction

  task automatic check_cycle(input string tag,
                             input logic [6:0] e_ctrl,
                             input logic [31:0] e_blk);
    @(negedge clk);
    chk({tag, ".ctrl"}, ctrl(), {25'd0, e_ctrl});
    chk({tag, ".blk"}, blk, e_blk);
    chk({tag, ".cnt"}, mcount, m_count);
    @(posedge clk);
    #1;
  endtask

  // One buffered access, including its whole stall and the retry.
  task automatic do_access(input string tag,
                           input bit r, input bit w, input bit n,
                           input logic [31:0] a,
                           input logic [31:0] v,
                           input bit h, input bit d);
    bit acc;
    int len;
    logic [6:0] e;
    logic [31:0] eb;
    acc = (r | w) & !n;
    rd = r; wr = w; nop = n; addr = a; victim = v;
    hit = h; dirty = d;
    if (!acc || h) begin
      e = (acc && w) ? 7'b0101100 : 7'b0;
      check_cycle({tag, ".hit"}, e, 32'd0);
      return;
    end
    len = 1 + L * (d ? 2 : 1);
    for (int k = 0; k < len; k++) begin
      e  = 7'b1000000;
      eb = 32'd0;
      if (k > 0) begin
        hit   = $urandom_range(1);
        dirty = $urandom_range(1);
        if (d && k <= L) begin
          e  = 7'b1000011;
          eb = v & ~32'h3;
        end else begin
          eb = a & ~32'h3;
          if (k == len - 1) e = 7'b1110100;
        end
      end
      check_cycle($sformatf("%s.stall%0d", tag, k), e, eb);
      if (k == 0 && m_count != 32'hFFFF_FFFF) m_count++;
    end
    hit = 1'b1; dirty = 1'b0;
    e = w ? 7'b0101100 : 7'b0;
    check_cycle({tag, ".retry"}, e, 32'd0);
  endtask

  initial begin
    rst_b = 1'b0;
    rd = 1'b1; wr = 1'b1; nop = 1'b0;
    addr = 32'h100; victim = 32'h800;
    hit = 1'b0; dirty = 1'b1;
    #3;
    chk("rst.ctrl", ctrl(), 32'd0);
    chk("rst.blk", blk, 32'd0);
    chk("rst.cnt", mcount, 32'd0);
    #20 rst_b = 1'b1;
    rd = 1'b0; wr = 1'b0;
    @(posedge clk);
    #1;

    do_access("ld_hit0", 1, 0, 0, 32'h40, 32'h0, 1, 0);
    do_access("ld_hit1", 1, 0, 0, 32'h40, 32'h0, 1, 1);
    do_access("st_hit", 0, 1, 0, 32'h44, 32'h0, 1, 1);
    do_access("idle", 0, 0, 0, 32'h48, 32'h0, 0, 1);
    do_access("clean_ld", 1, 0, 0, 32'h100, 32'h900, 0, 0);
    do_access("dirty_st", 0, 1, 0, 32'h204, 32'h800, 0, 1);
    do_access("nop_st", 0, 1, 1, 32'h300, 32'h800, 0, 1);
    do_access("rdwr_miss", 1, 1, 0, 32'h407, 32'hA03, 0, 1);

    // Reset in the second refill cycle abandons the miss.
    rd = 1'b1; wr = 1'b0; nop = 1'b0;
    addr = 32'h500; victim = 32'hC00;
    hit = 1'b0; dirty = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
    end
    rst_b = 1'b0;
    #1;
    chk("midrst.ctrl", ctrl(), 32'd0);
    chk("midrst.blk", blk, 32'd0);
    chk("midrst.cnt", mcount, 32'd0);
    m_count = 0;
    #1 rst_b = 1'b1;
    do_access("after_rst", 1, 0, 0, 32'h500, 32'hC00, 0, 0);

    for (int i = 0; i < 40; i++) begin
      do_access($sformatf("rnd%0d", i),
                $urandom_range(1), $urandom_range(1),
                ($urandom_range(3) == 0),
                $urandom, $urandom,
                $urandom_range(1), $urandom_range(1));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_controller.md
Name: mem_stage_controller

Overview:
MEM-stage consumer of the EX/MEM pipeline buffer. It takes the registered memory-control fields from that buffer, drives the data cache and backing memory, and returns the `lock` stall signal that freezes every pipeline buffer while a miss is serviced. The cache is write-back, allocate-on-miss. Memory has a fixed access latency.

Parameters:
MEM_LATENCY, 4, cycles per backing-memory block transfer; legal values are 1 and above.
CNT_W, 8, width of the latency counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
clk  input  1  system clock, rising edge
rst_b  input  1  asynchronous active-low reset
mem_read_mem  input  1  load in MEM (from EX/MEM buffer)
mem_write_mem  input  1  store in MEM (from EX/MEM buffer)
is_nop_mem  input  1  bubble; suppresses any access
ALU_result_mem  input  32  effective byte address
victim_addr  input  32  block address of the resident (victim) line, from the cache
cache_hit  input  1  combinational tag match and valid for ALU_result_mem
cache_dirty  input  1  victim line dirty
lock  output  1  stall to all pipeline buffers
we_cache  output  1  cache write enable
cache_input_type  output  1  0 = store data from the pipeline, 1 = refill data from memory
set_dirty  output  1  dirty bit value written with we_cache
set_valid  output  1  valid bit value written with we_cache
we_memory  output  1  memory write enable (writeback)
memory_address_type  output  1  0 = miss address, 1 = victim address
mem_block_addr  output  32  block address presented to memory, with the low 2 bits forced to 0
miss_count  output  32  number of misses serviced; saturating

Behaviour:
- Access condition: `access = (mem_read_mem | mem_write_mem) & ~is_nop_mem`. If read and write are both 1, the access is treated as a write.
- State machine has three states: IDLE, WRITEBACK, REFILL. There is one CNT_W-bit counter `cnt`.
- `miss_addr` is a 32-bit register. It latches `ALU_result_mem` when a miss is detected.
- All outputs other than `miss_count` are combinational from state, `cnt` and inputs. Any output not listed for a state is 0.
- IDLE, access and hit:
  - `lock` = 0.
  - On a write, also drive `we_cache`=1, `cache_input_type`=0, `set_dirty`=1, `set_valid`=1 in the same cycle.
  - A read needs no controls.
  - This is zero-stall.
- IDLE, access and miss:
  - `lock` = 1 in the same cycle, and `miss_addr` is latched.
  - If `cache_dirty`=1, go to WRITEBACK; otherwise go to REFILL. `cnt` is cleared.
  - `miss_count` increments at this edge and saturates at 0xFFFF_FFFF.
- WRITEBACK:
  - `lock`=1, `we_memory`=1, `memory_address_type`=1, `mem_block_addr`=`victim_addr`.
  - `cnt` increments each cycle. When `cnt`==MEM_LATENCY-1, go to REFILL with `cnt` cleared.
- REFILL:
  - `lock`=1, `memory_address_type`=0, `mem_block_addr`=`miss_addr`.
  - On the cycle `cnt`==MEM_LATENCY-1, also drive `we_cache`=1, `cache_input_type`=1, `set_valid`=1, `set_dirty`=0, then go to IDLE.
- Retry: when back in IDLE the buffered instruction is re-evaluated and now hits. A store writes and sets dirty in that cycle, with `lock`=0.
- Stall length:
  - Clean miss: `lock` is high for exactly 1+MEM_LATENCY cycles.
  - Dirty miss: `lock` is high for exactly 1+2·MEM_LATENCY cycles.
- Inputs in WRITEBACK and REFILL are ignored, because the buffer holds them stable under `lock`. `cache_hit` in these states is don't-care.
- `is_nop_mem`=1 never stalls and never writes, regardless of the read and write flags.
- Reset is asynchronous and active-low. It forces IDLE, `cnt`=0, `miss_addr`=0, `miss_count`=0. All outputs are 0 while reset is asserted and in IDLE with no access. Reset during WRITEBACK or REFILL abandons the transfer with no `we_cache` pulse.

Test Plan:
1. Reset, then a load hit at 0x40 -> `lock`=0 every cycle, `we_cache`=0, `miss_count`=0.
2. Store hit at 0x44 -> a single cycle with `we_cache`=1, `cache_input_type`=0, `set_dirty`=1, `lock`=0.
3. Clean load miss at 0x100, MEM_LATENCY=4 -> `lock` high for 5 cycles; `mem_block_addr`=0x100 during REFILL; `we_cache`/`set_valid` pulse in cycle 5; `miss_count`=1.
4. Dirty store miss at 0x204, `victim_addr`=0x800 -> `we_memory`=1 for 4 cycles with `mem_block_addr`=0x800, then 4 REFILL cycles at 0x204, `lock` high for 9 cycles total; on the retry cycle `we_cache`=1 and `set_dirty`=1.
5. `is_nop_mem`=1 with `mem_write_mem`=1 and `cache_hit`=0 -> no `lock`, no writes, `miss_count` unchanged.
6. `rst_b` dropped during the 2nd REFILL cycle -> outputs go to 0 immediately; after release, IDLE and `miss_count`=0; the re-presented access misses again and is serviced normally.
